seq_detect_ctrl: RTL and testbench
==================================

SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 Parameter: CNT_W, default 4, width of the saturating match counter.
REQ-002 Parameter: LEN_W, default 8, width of the frame-length field.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 start  input  1  request to begin a detection frame; sampled only in IDLE.
REQ-006 pattern  input  4  target pattern; pattern[3] is the first serial bit, pattern[0] the last.
REQ-007 len  input  LEN_W  number of serial bits in the frame.
REQ-008 x  input  1  serial data bit, sampled once per clock in RUN.
REQ-009 busy  output  1  high while in RUN.
REQ-010 z  output  1  Mealy match flag, combinational on x.
REQ-011 match_cnt  output  CNT_W  matches found in the current or last frame.
REQ-012 done  output  1  one-cycle pulse marking frame completion.

Function
REQ-013 The FSM SHALL have three states, IDLE, RUN and DONE, with the following transitions.
  - IDLE -> RUN on start=1 with len!=0.
  - IDLE -> DONE on start=1 with len=0.
  - RUN -> DONE on the edge that samples bit number len.
  - DONE -> IDLE unconditionally after one cycle.
REQ-014 On the edge that accepts start, the block SHALL latch pattern and len, clear match_cnt, the bit counter and the history, and zero the history-valid count.
REQ-015 start in RUN or DONE SHALL be ignored; changes to pattern, len or start during RUN SHALL NOT affect the frame in progress.
REQ-016 In RUN, each edge SHALL shift x into a 3-bit history (h[2] oldest) and increment the bit counter and the history-valid count (valid count saturates at 3).
REQ-017 z SHALL be 1 iff state=RUN, valid count=3, and {h[2],h[1],h[0],x} equals the latched pattern; otherwise z SHALL be 0.
REQ-018 Matching SHALL allow overlap: the history is never cleared on a match.
REQ-019 match_cnt SHALL increment on each edge where z=1, and SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-020 match_cnt SHALL hold its value from DONE until the next accepted start.
REQ-021 done SHALL be 1 exactly during the DONE cycle, which is the cycle after the last bit is sampled, or the cycle after start when len=0; done SHALL be 0 otherwise.
REQ-022 busy SHALL be 1 in RUN only, and 0 in IDLE and DONE.
REQ-023 When the frame ends before 3 history bits are valid (len<4), no match SHALL be reported.

Reset
REQ-024 While reset=0, the block SHALL immediately force the following, independent of clk:
  - state = IDLE;
  - busy = 0, done = 0, z = 0, match_cnt = 0;
  - history, valid count and bit counter cleared.
REQ-025 Reset asserted mid-RUN SHALL abort the frame with no done pulse.
REQ-026 After reset is released, the first start SHALL be accepted normally.

Verification
REQ-027 Serial match with overlap: pattern=0110, len=12, x=0,0,1,1,0,1,1,0,0,1,1,0 -> z high while bits 5, 8 and 12 are presented; match_cnt=3; done high for one cycle after the 12th sample.
REQ-028 Zero-length frame: len=0, start=1 -> busy stays 0, done=1 on the next cycle, match_cnt=0.
REQ-029 Counter saturation: pattern=1111, len=20, x held at 1 -> 17 raw matches, match_cnt saturates at 15 and holds 15 after done.
REQ-030 Short frame: pattern=0000, len=3, x=0,0,0 -> z never asserted, match_cnt=0, done pulse after the 3rd sample.
REQ-031 Mid-frame reset: assert reset=0 during bit 5 of a 12-bit frame -> all outputs 0 immediately, no done pulse; after release, a new start with pattern=0110 runs a correct frame.
REQ-032 Ignored start: pulse start and change pattern to 1001 during RUN of the REQ-027 frame -> results are unchanged (match_cnt=3, single done pulse).

Source files
------------

// File: rtl/seq_detect_ctrl_if.sv
// Handshake/data bundle between a frame controller and the serial pattern detector.
// The master drives the frame request and serial data; the slave is the detector.
interface seq_detect_ctrl_if #(
    parameter int CNT_W = 4,
    parameter int LEN_W = 8
);
    logic             start;
    logic [3:0]       pattern;
    logic [LEN_W-1:0] len;
    logic             x;
    logic             busy;
    logic             z;
    logic [CNT_W-1:0] match_cnt;
    logic             done;

    modport master (
        output start, pattern, len, x,
        input  busy, z, match_cnt, done
    );

    modport slave (
        input  start, pattern, len, x,
        output busy, z, match_cnt, done
    );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Framed serial 4-bit pattern detector with overlapping matches, a Mealy match
// flag and a saturating per-frame match counter.
module seq_detect_ctrl #(
    parameter int CNT_W = 4,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    seq_detect_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_pat;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_bitcnt;
    logic [2:0]       r_hist;
    logic [1:0]       r_vcnt;
    logic [CNT_W-1:0] r_match_cnt;

    logic             w_accept;
    logic             w_last;
    logic             w_busy;
    logic             w_done;
    logic             w_z;

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [1:0] sat_inc_vcnt(input logic [1:0] v);
        return (v == 2'd3) ? v : v + 2'd1;
    endfunction

    assign w_accept = (r_state == IDLE) && bus.start;
    // r_bitcnt counts bits already sampled, so this edge samples bit r_bitcnt+1
    assign w_last   = (r_bitcnt == r_len - LEN_W'(1));

    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        w_z    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next = (bus.len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                w_busy = 1'b1;
                w_z    = (r_vcnt == 2'd3) && ({r_hist, bus.x} == r_pat);
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pat       <= '0;
            r_len       <= '0;
            r_bitcnt    <= '0;
            r_hist      <= '0;
            r_vcnt      <= '0;
            r_match_cnt <= '0;
        end else if (w_accept) begin
            r_pat       <= bus.pattern;
            r_len       <= bus.len;
            r_bitcnt    <= '0;
            r_hist      <= '0;
            r_vcnt      <= '0;
            r_match_cnt <= '0;
        end else if (r_state == RUN) begin
            // History is never cleared on a match, so overlapping matches are found
            r_hist   <= {r_hist[1:0], bus.x};
            r_bitcnt <= r_bitcnt + LEN_W'(1);
            r_vcnt   <= sat_inc_vcnt(r_vcnt);
            if (w_z) begin
                r_match_cnt <= sat_inc_cnt(r_match_cnt);
            end
        end
    end

    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.z         = w_z;
    assign bus.match_cnt = r_match_cnt;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench for seq_detect_ctrl: frame tasks queue expected results, a
// negedge monitor collects z activity per frame and checks at each done pulse.
module tb_seq_detect_ctrl;
    localparam int CNT_W = 4;
    localparam int LEN_W = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seq_detect_ctrl_if #(.CNT_W(CNT_W), .LEN_W(LEN_W)) bus ();

    seq_detect_ctrl #(.CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    typedef struct {
        logic [CNT_W-1:0] cnt;
        logic [31:0]      zmask;
        int               raw;
        bit               busy_exp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    endtask

    // Monitor: accumulate z positions while busy, compare at done, then check hold
    initial begin
        logic [31:0]      mask;
        int               raw;
        int               idx;
        bit               seen_busy;
        bit               hold_chk;
        logic [CNT_W-1:0] held;
        exp_t             e;
        mask = '0; raw = 0; idx = 0; seen_busy = 0; hold_chk = 0; held = '0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                mask = '0; raw = 0; idx = 0; seen_busy = 0; hold_chk = 0;
            end else begin
                if (hold_chk) begin
                    check("cnt_hold_after_done", 32'(bus.match_cnt), 32'(held));
                    check("done_single_cycle", 32'(bus.done), 32'd0);
                    hold_chk = 0;
                end
                if (bus.busy === 1'b1) begin
                    seen_busy = 1;
                    if (bus.z === 1'b1) begin
                        raw++;
                        if (idx < 32) mask[idx] = 1'b1;
                    end
                    idx++;
                end else if (bus.z !== 1'b0) begin
                    check("z_outside_run", 32'(bus.z), 32'd0);
                end
                if (bus.done === 1'b1) begin
                    check("busy_low_in_done", 32'(bus.busy), 32'd0);
                    if (sb.size() == 0) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("match_cnt", 32'(bus.match_cnt), 32'(e.cnt));
                        check("z_positions", mask, e.zmask);
                        check("raw_matches", 32'(raw), 32'(e.raw));
                        check("busy_seen", 32'(seen_busy), 32'(e.busy_exp));
                        held = bus.match_cnt;
                        hold_chk = 1;
                    end
                    mask = '0; raw = 0; idx = 0; seen_busy = 0;
                end
            end
        end
    end

    // Entered and left at posedge+1; bits[i] is serial bit number i+1
    task automatic run_frame(input logic [3:0] pat, input logic [LEN_W-1:0] n,
                             input logic [31:0] bits, input logic [CNT_W-1:0] exp_cnt,
                             input logic [31:0] exp_mask, input int exp_raw, input bit ign);
        exp_t e;
        int   k;
        e.cnt = exp_cnt; e.zmask = exp_mask; e.raw = exp_raw; e.busy_exp = (n != 0);
        sb.push_back(e);
        bus.start = 1'b1; bus.pattern = pat; bus.len = n;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < int'(n); i++) begin
            bus.x = bits[i];
            if (ign && i == 3) begin
                bus.start = 1'b1; bus.pattern = 4'b1001; bus.len = 8'd5;
            end
            if (ign && i == 4) begin
                bus.start = 1'b0; bus.pattern = pat; bus.len = n;
            end
            @(posedge clk); #1;
        end
        bus.x = 1'b0;
        k = 0;
        while (sb.size() != 0 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        if (sb.size() != 0) begin
            check("done_timeout", 32'd1, 32'd0);
            sb.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] bits27;
        bits27 = 32'h0000_066C;
        reset = 1'b0;
        bus.start = 1'b0; bus.pattern = '0; bus.len = '0; bus.x = 1'b0;
        #12;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_z", 32'(bus.z), 32'd0);
        check("rst_match_cnt", 32'(bus.match_cnt), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Overlapping serial match: hits on bits 5, 8, 12
        run_frame(4'b0110, 8'd12, bits27, 4'd3, 32'h0000_0890, 3, 1'b0);
        // Zero-length frame
        run_frame(4'b0110, 8'd0, 32'h0, 4'd0, 32'h0, 0, 1'b0);
        // Saturation: 17 raw matches, counter stops at 15
        run_frame(4'b1111, 8'd20, 32'h000F_FFFF, 4'd15, 32'h000F_FFF8, 17, 1'b0);
        // Short frame never matches
        run_frame(4'b0000, 8'd3, 32'h0, 4'd0, 32'h0, 0, 1'b0);
        // Overlap sharing a bit: 1001001 hits on bits 4 and 7
        run_frame(4'b1001, 8'd8, 32'h0000_00C9, 4'd2, 32'h0000_0048, 2, 1'b0);
        // Start and pattern changes during RUN are ignored
        run_frame(4'b0110, 8'd12, bits27, 4'd3, 32'h0000_0890, 3, 1'b1);

        // Mid-frame reset during bit 5 (where z would otherwise be high)
        bus.start = 1'b1; bus.pattern = 4'b0110; bus.len = 8'd12;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.x = bits27[i];
            if (i == 4) begin
                #2;
                reset = 1'b0;
                #1;
                check("midrst_busy", 32'(bus.busy), 32'd0);
                check("midrst_done", 32'(bus.done), 32'd0);
                check("midrst_z", 32'(bus.z), 32'd0);
                check("midrst_match_cnt", 32'(bus.match_cnt), 32'd0);
            end else begin
                @(posedge clk); #1;
            end
        end
        bus.x = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_idle_busy", 32'(bus.busy), 32'd0);
        run_frame(4'b0110, 8'd12, bits27, 4'd3, 32'h0000_0890, 3, 1'b0);

        repeat (5) @(posedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
